rf_write_arbiter: RTL and testbench

RF_WRITE_ARBITER -- requirements
Module: rf_write_arbiter

---
 rtl/rf_write_arbiter_if.sv | 42 ++++
 rtl/rf_write_arbiter.sv | 103 ++++++++++
 tb/tb_rf_write_arbiter.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/rf_write_arbiter_if.sv
// ---------------------------------------------------------------------------
// rf_write_arbiter_if
// Bundles the two write-request channels, the grant/status outputs and the
// read port of rf_write_arbiter.
//   req0/req1     : write requests, held until granted
//   addr0/addr1   : target register per requester
//   wdata0/wdata1 : write data per requester
//   gnt0/gnt1     : one-cycle grant pulses
//   busy          : high while a write is being granted
//   rd_addr       : read address
//   rd_data       : combinational read data
//   wr_count      : committed write count (8 bit, wrapping)
// ---------------------------------------------------------------------------
interface rf_write_arbiter_if #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 4
);
   localparam int AW = $clog2(DEPTH);

   logic              req0;
   logic              req1;
   logic [AW-1:0]     addr0;
   logic [AW-1:0]     addr1;
   logic [DATA_W-1:0] wdata0;
   logic [DATA_W-1:0] wdata1;
   logic              gnt0;
   logic              gnt1;
   logic              busy;
   logic [AW-1:0]     rd_addr;
   logic [DATA_W-1:0] rd_data;
   logic [7:0]        wr_count;

   modport master (
      output req0, req1, addr0, addr1, wdata0, wdata1, rd_addr,
      input  gnt0, gnt1, busy, rd_data, wr_count
   );

   modport slave (
      input  req0, req1, addr0, addr1, wdata0, wdata1, rd_addr,
      output gnt0, gnt1, busy, rd_data, wr_count
   );
endinterface

// File: rtl/rf_write_arbiter.sv
// ---------------------------------------------------------------------------
// rf_write_arbiter
// Two-requester round-robin write arbiter in front of a small register file.
// A request seen in IDLE is latched (index, address, data) and the FSM moves
// to GRANT; the grant cycle drives the winner's gnt and the write commits on
// the edge that leaves GRANT. One write per two cycles at most.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : rf_write_arbiter_if slave modport (requests, grants, read port)
// ---------------------------------------------------------------------------
module rf_write_arbiter #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 4
) (
   input  logic           clk,
   input  logic           rst_n,
   rf_write_arbiter_if.slave bus
);
   localparam int AW = $clog2(DEPTH);

   typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

   state_t            state_q, state_d;
   logic              sel_q, sel_d;
   logic [AW-1:0]     addr_q, addr_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic              last_win_q, last_win_d;
   logic [7:0]        wr_count_q, wr_count_d;
   logic [DATA_W-1:0] regs_q [DEPTH];
   logic [DATA_W-1:0] regs_d [DEPTH];

   logic              winner;
   logic              gnt0, gnt1, busy;

   // State register (FSM plus all datapath storage)
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         sel_q      <= 1'b0;
         addr_q     <= '0;
         data_q     <= '0;
         last_win_q <= 1'b1;   // requester 0 wins the first contention
         wr_count_q <= 8'd0;
         for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
      end else begin
         state_q    <= state_d;
         sel_q      <= sel_d;
         addr_q     <= addr_d;
         data_q     <= data_d;
         last_win_q <= last_win_d;
         wr_count_q <= wr_count_d;
         for (int i = 0; i < DEPTH; i++) regs_q[i] <= regs_d[i];
      end
   end

   // Under contention the requester not served last wins; otherwise the
   // sole active requester (req1 low means requester 0).
   assign winner = (bus.req0 && bus.req1) ? ~last_win_q : bus.req1;

   // Next-state logic
   always_comb begin
      state_d    = state_q;
      sel_d      = sel_q;
      addr_d     = addr_q;
      data_d     = data_q;
      last_win_d = last_win_q;
      wr_count_d = wr_count_q;
      for (int i = 0; i < DEPTH; i++) regs_d[i] = regs_q[i];

      case (state_q)
         IDLE: begin
            if (bus.req0 || bus.req1) begin
               state_d = GRANT;
               sel_d   = winner;
               addr_d  = winner ? bus.addr1  : bus.addr0;
               data_d  = winner ? bus.wdata1 : bus.wdata0;
            end
         end
         GRANT: begin
            // Commit uses only latched values, so input changes during the
            // grant cycle cannot disturb the write.
            regs_d[addr_q] = data_q;
            last_win_d     = sel_q;
            wr_count_d     = wr_count_q + 8'd1;
            state_d        = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Output logic
   always_comb begin
      busy = (state_q == GRANT);
      gnt0 = busy && !sel_q;
      gnt1 = busy &&  sel_q;
   end

   assign bus.busy     = busy;
   assign bus.gnt0     = gnt0;
   assign bus.gnt1     = gnt1;
   assign bus.wr_count = wr_count_q;
   assign bus.rd_data  = regs_q[bus.rd_addr];
endmodule

// File: tb/tb_rf_write_arbiter.sv
module tb_rf_write_arbiter;
   localparam int DATA_W = 8;
   localparam int DEPTH  = 4;

   logic clk;
   logic rst_n;

   rf_write_arbiter_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

   rf_write_arbiter #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int vectors     = 0;
   int miscompares = 0;
   bit chk_en      = 1'b0;

   // Reference model: register file contents, a single in-flight write
   // (who, where, what), the requester served last and the commit counter.
   logic [7:0] m_mem [DEPTH];
   bit         m_inflight;
   int         m_who;
   int         m_where;
   logic [7:0] m_what;
   int         m_last;
   int         m_count;

   task automatic expect_val(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, required %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < DEPTH; i++) m_mem[i] = 8'h00;
      m_inflight = 1'b0;
      m_who      = 0;
      m_where    = 0;
      m_what     = 8'h00;
      m_last     = 1;
      m_count    = 0;
   endtask

   // One rising edge worth of behaviour, from the requirements' rules.
   task automatic model_step();
      if (m_inflight) begin
         m_mem[m_where] = m_what;
         m_last         = m_who;
         m_count        = (m_count + 1) % 256;
         m_inflight     = 1'b0;
      end else if (bus.req0 || bus.req1) begin
         if (bus.req0 && bus.req1) m_who = 1 - m_last;
         else                      m_who = bus.req1 ? 1 : 0;
         m_where    = (m_who == 1) ? int'(bus.addr1) : int'(bus.addr0);
         m_what     = (m_who == 1) ? bus.wdata1 : bus.wdata0;
         m_inflight = 1'b1;
      end
   endtask

   // Advance one clock; inputs are changed by the caller 1 ns after the edge.
   task automatic cycle();
      @(posedge clk);
      if (rst_n) model_step();
      #1;
   endtask

   task automatic hard_reset();
      rst_n = 1'b0;
      model_reset();
      cycle();
      cycle();
      rst_n = 1'b1;
   endtask

   // Compare process: every falling edge, DUT against the model.
   always @(negedge clk) begin
      if (chk_en) begin
         expect_val("gnt0",     bus.gnt0,     (m_inflight && m_who == 0));
         expect_val("gnt1",     bus.gnt1,     (m_inflight && m_who == 1));
         expect_val("busy",     bus.busy,     m_inflight);
         expect_val("wr_count", bus.wr_count, m_count[7:0]);
         expect_val("rd_data",  bus.rd_data,  m_mem[bus.rd_addr]);
         expect_val("gnt_excl", (bus.gnt0 && bus.gnt1), 1'b0);
      end
   end

   initial begin
      rst_n      = 1'b0;
      bus.req0   = 1'b0;
      bus.req1   = 1'b0;
      bus.addr0  = '0;
      bus.addr1  = '0;
      bus.wdata0 = '0;
      bus.wdata1 = '0;
      bus.rd_addr = '0;
      model_reset();
      #2;
      chk_en = 1'b1;
      expect_val("rst_busy",  bus.busy, 1'b0);
      expect_val("rst_gnt0",  bus.gnt0, 1'b0);
      expect_val("rst_count", bus.wr_count, 8'd0);
      expect_val("rst_rd",    bus.rd_data, 8'h00);
      cycle();
      cycle();
      rst_n = 1'b1;

      // Single request: addr 2 <- A5
      bus.req0 = 1'b1; bus.addr0 = 2'd2; bus.wdata0 = 8'hA5;
      cycle();
      expect_val("single_gnt0", bus.gnt0, 1'b1);
      expect_val("single_gnt1", bus.gnt1, 1'b0);
      bus.req0 = 1'b0;
      cycle();
      bus.rd_addr = 2'd2; #1;
      expect_val("single_rd",    bus.rd_data, 8'hA5);
      expect_val("single_count", bus.wr_count, 8'd1);

      // Contention after reset: 0, 1, 0
      hard_reset();
      bus.req0 = 1'b1; bus.addr0 = 2'd0; bus.wdata0 = 8'h11;
      bus.req1 = 1'b1; bus.addr1 = 2'd1; bus.wdata1 = 8'h22;
      cycle(); expect_val("cont_g1_gnt0", bus.gnt0, 1'b1);
      cycle(); expect_val("cont_gap",     bus.busy, 1'b0);
      cycle(); expect_val("cont_g2_gnt1", bus.gnt1, 1'b1);
               expect_val("cont_g2_gnt0", bus.gnt0, 1'b0);
      cycle();
      cycle(); expect_val("cont_g3_gnt0", bus.gnt0, 1'b1);
      bus.req0 = 1'b0; bus.req1 = 1'b0;
      cycle();
      bus.rd_addr = 2'd0; #1; expect_val("cont_reg0", bus.rd_data, 8'h11);
      bus.rd_addr = 2'd1; #1; expect_val("cont_reg1", bus.rd_data, 8'h22);

      // Data change during the grant cycle is ignored
      bus.req1 = 1'b1; bus.addr1 = 2'd2; bus.wdata1 = 8'h33;
      cycle();
      bus.wdata1 = 8'hFF; bus.req1 = 1'b0;
      cycle();
      bus.rd_addr = 2'd2; #1; expect_val("hold_data", bus.rd_data, 8'h33);

      // Read during write: reg1 22 -> 5A
      bus.rd_addr = 2'd1;
      bus.req0 = 1'b1; bus.addr0 = 2'd1; bus.wdata0 = 8'h5A;
      cycle();
      bus.req0 = 1'b0; #1;
      expect_val("rdw_old", bus.rd_data, 8'h22);
      cycle();
      expect_val("rdw_new", bus.rd_data, 8'h5A);

      // Reset in the grant cycle aborts the write
      bus.req1 = 1'b1; bus.addr1 = 2'd3; bus.wdata1 = 8'h77;
      cycle();
      expect_val("abort_pre_gnt1", bus.gnt1, 1'b1);
      rst_n = 1'b0; model_reset(); bus.req1 = 1'b0; #1;
      expect_val("abort_gnt1", bus.gnt1, 1'b0);
      expect_val("abort_busy", bus.busy, 1'b0);
      cycle(); cycle();
      rst_n = 1'b1;
      bus.rd_addr = 2'd3; #1;
      expect_val("abort_reg3",  bus.rd_data, 8'h00);
      expect_val("abort_count", bus.wr_count, 8'd0);
      bus.req0 = 1'b1; bus.req1 = 1'b1;
      cycle();
      expect_val("abort_next_gnt0", bus.gnt0, 1'b1);
      bus.req0 = 1'b0; bus.req1 = 1'b0;
      cycle();

      // Counter wrap: 256 then 257 commits with req0 held
      hard_reset();
      bus.req0 = 1'b1;
      for (int i = 0; i < 512; i++) begin
         bus.addr0  = 2'($urandom_range(3, 0));
         bus.wdata0 = 8'($urandom);
         cycle();
      end
      expect_val("wrap_256", bus.wr_count, 8'd0);
      cycle(); cycle();
      expect_val("wrap_257", bus.wr_count, 8'd1);
      bus.req0 = 1'b0;
      cycle(); cycle();

      // Random traffic with occasional resets
      for (int i = 0; i < 3000; i++) begin
         bus.req0    = ($urandom_range(99, 0) < 60);
         bus.req1    = ($urandom_range(99, 0) < 60);
         bus.addr0   = 2'($urandom_range(3, 0));
         bus.addr1   = 2'($urandom_range(3, 0));
         bus.wdata0  = 8'($urandom);
         bus.wdata1  = 8'($urandom);
         bus.rd_addr = 2'($urandom_range(3, 0));
         if ($urandom_range(299, 0) == 0) begin
            rst_n = 1'b0;
            model_reset();
         end else begin
            rst_n = 1'b1;
         end
         cycle();
      end
      rst_n = 1'b1;
      bus.req0 = 1'b0; bus.req1 = 1'b0;
      cycle(); cycle(); cycle();

      chk_en = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
